// File: rtl/gpio_in_cond_if.sv
// GPIO input conditioner bundle: pad side inputs and conditioned outputs.
// Interrupt signals exist only when GPIO_IN_COND_IRQ_EN is defined.
interface gpio_in_cond_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] pad_i;
    logic [WIDTH-1:0] dbnc_en;
    logic [WIDTH-1:0] gpio_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
`ifdef GPIO_IN_COND_IRQ_EN
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] irq_clr;
    logic [WIDTH-1:0] irq_pend;
    logic             irq;

    modport master (
        output pad_i, dbnc_en, irq_mask, irq_clr,
        input  gpio_o, rise_o, fall_o, irq_pend, irq
    );
    modport slave (
        input  pad_i, dbnc_en, irq_mask, irq_clr,
        output gpio_o, rise_o, fall_o, irq_pend, irq
    );
`else
    modport master (
        output pad_i, dbnc_en,
        input  gpio_o, rise_o, fall_o
    );
    modport slave (
        input  pad_i, dbnc_en,
        output gpio_o, rise_o, fall_o
    );
`endif
endinterface

// File: rtl/gpio_in_cond.sv
// Per-bit 2-FF synchronizer, debounce filter and edge pulses for GPIO pad inputs.
// Optional sticky interrupt logic is enabled by defining GPIO_IN_COND_IRQ_EN.
module gpio_in_cond #(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      DEBOUNCE_CYCLES = 45000,
    parameter logic [WIDTH-1:0] INIT            = '0
) (
    input logic           hclk,
    input logic           RESET,
    gpio_in_cond_if.slave bus
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // Counter only advances on a persistent mismatch; any agreement or bypass clears it.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (!bus.dbnc_en[i]) begin
                stable_d[i] = s2_q[i];
            end else if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        rise_d = stable_d & ~stable_q;
        fall_d = ~stable_d & stable_q;
    end

    always_ff @(posedge hclk) begin
        if (RESET) begin
            s1_q     <= INIT;
            s2_q     <= INIT;
            stable_q <= INIT;
            rise_q   <= '0;
            fall_q   <= '0;
            cnt_q    <= '{default: '0};
        end else begin
            s1_q     <= bus.pad_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.gpio_o = stable_q;
    assign bus.rise_o = rise_q;
    assign bus.fall_o = fall_q;

`ifdef GPIO_IN_COND_IRQ_EN
    logic [WIDTH-1:0] pend_q, pend_d;

    // Set term is ORed last so a new edge wins over a same-cycle clear.
    always_comb begin
        pend_d = (pend_q & ~bus.irq_clr) | ((rise_q | fall_q) & bus.irq_mask);
    end

    always_ff @(posedge hclk) begin
        if (RESET) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign bus.irq_pend = pend_q;
    assign bus.irq      = |pend_q;
`endif
endmodule

// File: tb/tb_gpio_in_cond.sv
// Self-checking bench for gpio_in_cond: directed scenarios plus randomized traffic
// compared against a timestamp-based reference model.
module tb_gpio_in_cond;
    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic hclk = 1'b0;
    logic RESET;
    int   errors = 0;
    int   checks = 0;

    gpio_in_cond_if #(.WIDTH(W)) bus ();

    gpio_in_cond #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(N),
        .INIT(8'h00)
    ) dut (
        .hclk (hclk),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 hclk = ~hclk;

    // Reference model: a level is accepted once N edges have elapsed since the bit last
    // agreed with the accepted level (or was bypassed / accepted / reset).
    logic [W-1:0] m_s1, m_s2, m_stable, m_rise, m_fall, m_pend;
    int           edge_no = 0;
    int           last_ok [W];

    task automatic model_edge();
        logic [W-1:0] nxt;
        edge_no++;
        if (RESET) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0;
            m_rise = '0; m_fall = '0; m_pend = '0;
            for (int b = 0; b < int'(W); b++) last_ok[b] = edge_no;
        end else begin
            nxt = m_stable;
            for (int b = 0; b < int'(W); b++) begin
                if (!bus.dbnc_en[b] || m_s2[b] == m_stable[b]) begin
                    nxt[b] = m_s2[b];
                    last_ok[b] = edge_no;
                end else if (edge_no - last_ok[b] >= int'(N)) begin
                    nxt[b] = m_s2[b];
                    last_ok[b] = edge_no;
                end
            end
`ifdef GPIO_IN_COND_IRQ_EN
            m_pend = (m_pend & ~bus.irq_clr) | ((m_rise | m_fall) & bus.irq_mask);
`endif
            m_rise   = nxt & ~m_stable;
            m_fall   = ~nxt & m_stable;
            m_stable = nxt;
            m_s2     = m_s1;
            m_s1     = bus.pad_i;
        end
    endtask

    task automatic step();
        @(posedge hclk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.pad_i = 8'hFF;
        bus.dbnc_en = 8'h00;
`ifdef GPIO_IN_COND_IRQ_EN
        bus.irq_mask = '0;
        bus.irq_clr = '0;
`endif
        step(); step();
        checks++;
        if (bus.gpio_o !== 8'h00) begin
            errors++; $display("FAIL reset_gpio: got %h want 00", bus.gpio_o);
        end
        checks++;
        if (bus.rise_o !== 8'h00 || bus.fall_o !== 8'h00) begin
            errors++; $display("FAIL reset_pulse: got rise %h fall %h want 00/00", bus.rise_o, bus.fall_o);
        end
        RESET = 1'b0;
        step(); step();
        checks++;
        if (bus.gpio_o !== 8'h00) begin
            errors++; $display("FAIL reset_early: got %h want 00 two edges after release", bus.gpio_o);
        end
        step();
        checks++;
        if (bus.gpio_o !== 8'hFF || bus.rise_o !== 8'hFF) begin
            errors++; $display("FAIL reset_release: got gpio %h rise %h want FF/FF", bus.gpio_o, bus.rise_o);
        end
    endtask

    task automatic test_bypass();
        bus.pad_i = 8'h00;
        repeat (4) step();
        bus.pad_i = 8'h01;
        step(); step();
        checks++;
        if (bus.gpio_o[0] !== 1'b0) begin
            errors++; $display("FAIL bypass_early: got %b want 0 after edge k+1", bus.gpio_o[0]);
        end
        step();
        checks++;
        if (bus.gpio_o !== 8'h01 || bus.rise_o !== 8'h01) begin
            errors++; $display("FAIL bypass_rise: got gpio %h rise %h want 01/01", bus.gpio_o, bus.rise_o);
        end
        step();
        checks++;
        if (bus.rise_o !== 8'h00 || bus.gpio_o !== 8'h01) begin
            errors++; $display("FAIL bypass_pulse_end: got gpio %h rise %h want 01/00", bus.gpio_o, bus.rise_o);
        end
    endtask

    task automatic test_debounce();
        bus.dbnc_en = 8'hFF;
        bus.pad_i = 8'h03;
        repeat (5) step();
        checks++;
        if (bus.gpio_o[1] !== 1'b0) begin
            errors++; $display("FAIL dbnc_early: got %b want 0 after edge k+4", bus.gpio_o[1]);
        end
        step();
        checks++;
        if (bus.gpio_o !== 8'h03 || bus.rise_o !== 8'h02) begin
            errors++; $display("FAIL dbnc_accept: got gpio %h rise %h want 03/02", bus.gpio_o, bus.rise_o);
        end
        bus.pad_i = 8'h07;
        for (int c = 0; c < 13; c++) begin
            if (c == 3) bus.pad_i = 8'h03;
            step();
            checks++;
            if (bus.gpio_o !== 8'h03 || bus.rise_o !== 8'h00 || bus.fall_o !== 8'h00) begin
                errors++;
                $display("FAIL dbnc_glitch[%0d]: got gpio %h rise %h fall %h want 03/00/00",
                         c, bus.gpio_o, bus.rise_o, bus.fall_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.pad_i = 8'h0B;
        repeat (4) step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        checks++;
        if (bus.gpio_o !== 8'h00 || bus.rise_o !== 8'h00 || bus.fall_o !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_clear: got gpio %h rise %h fall %h want 00/00/00",
                     bus.gpio_o, bus.rise_o, bus.fall_o);
        end
        repeat (5) step();
        checks++;
        if (bus.gpio_o[3] !== 1'b0) begin
            errors++; $display("FAIL rstmid_early: got %b want 0 five edges after release", bus.gpio_o[3]);
        end
        step();
        checks++;
        if (bus.gpio_o !== 8'h0B || bus.rise_o !== 8'h0B) begin
            errors++; $display("FAIL rstmid_accept: got gpio %h rise %h want 0B/0B", bus.gpio_o, bus.rise_o);
        end
    endtask

    task automatic test_mode_switch();
        bus.pad_i = 8'h1B;
        repeat (5) step();
        bus.dbnc_en = 8'hEF;
        step();
        checks++;
        if (bus.gpio_o !== 8'h1B || bus.rise_o !== 8'h10) begin
            errors++; $display("FAIL mode_pass: got gpio %h rise %h want 1B/10", bus.gpio_o, bus.rise_o);
        end
        step();
        checks++;
        if (bus.gpio_o !== 8'h1B || bus.rise_o !== 8'h00 || bus.fall_o !== 8'h00) begin
            errors++;
            $display("FAIL mode_once: got gpio %h rise %h fall %h want 1B/00/00",
                     bus.gpio_o, bus.rise_o, bus.fall_o);
        end
        bus.dbnc_en = 8'hFF;
    endtask

`ifdef GPIO_IN_COND_IRQ_EN
    task automatic test_irq();
        bus.dbnc_en = 8'h00;
        bus.pad_i = 8'h00;
        repeat (4) step();
        bus.irq_mask = 8'h01;
        bus.pad_i = 8'h01;
        repeat (4) step();
        checks++;
        if (bus.irq_pend !== 8'h01 || bus.irq !== 1'b1) begin
            errors++; $display("FAIL irq_set: got pend %h irq %b want 01/1", bus.irq_pend, bus.irq);
        end
        bus.pad_i = 8'h00;
        repeat (3) step();
        checks++;
        if (bus.fall_o !== 8'h01) begin
            errors++; $display("FAIL irq_fall: got fall %h want 01", bus.fall_o);
        end
        bus.irq_clr = 8'h01;
        step();
        checks++;
        if (bus.irq_pend !== 8'h01) begin
            errors++; $display("FAIL irq_set_wins: got pend %h want 01", bus.irq_pend);
        end
        step();
        bus.irq_clr = 8'h00;
        checks++;
        if (bus.irq_pend !== 8'h00 || bus.irq !== 1'b0) begin
            errors++; $display("FAIL irq_clear: got pend %h irq %b want 00/0", bus.irq_pend, bus.irq);
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] flip;
        for (int c = 0; c < 3000; c++) begin
            flip = '0;
            for (int b = 0; b < int'(W); b++) flip[b] = ($urandom_range(5) == 0);
            bus.pad_i = bus.pad_i ^ flip;
            if ($urandom_range(40) == 0) bus.dbnc_en = W'($urandom);
            RESET = ($urandom_range(300) == 0);
`ifdef GPIO_IN_COND_IRQ_EN
            bus.irq_mask = W'($urandom);
            bus.irq_clr = ($urandom_range(3) == 0) ? W'($urandom) : '0;
`endif
            step();
            checks++;
            if (bus.gpio_o !== m_stable || bus.rise_o !== m_rise || bus.fall_o !== m_fall) begin
                errors++;
                $display("FAIL random[%0d]: got gpio %h rise %h fall %h want %h/%h/%h",
                         c, bus.gpio_o, bus.rise_o, bus.fall_o, m_stable, m_rise, m_fall);
            end
`ifdef GPIO_IN_COND_IRQ_EN
            checks++;
            if (bus.irq_pend !== m_pend || bus.irq !== (|m_pend)) begin
                errors++;
                $display("FAIL random_irq[%0d]: got pend %h irq %b want %h/%b",
                         c, bus.irq_pend, bus.irq, m_pend, |m_pend);
            end
`endif
        end
        RESET = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_debounce();
        test_reset_mid();
        test_mode_switch();
`ifdef GPIO_IN_COND_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
